// File: rtl/dual_port_arb_ram_pkg.sv
// Shared constants for the CPU/DMA arbitrated RAM: arbitration modes,
// master indices and the round-robin pointer encoding.
package dual_port_arb_ram_pkg;

    localparam int ARB_RR       = 0;
    localparam int ARB_CPU_PRIO = 1;

    localparam int MST_CPU = 0;
    localparam int MST_DMA = 1;
    localparam int NUM_MST = 2;

    typedef enum logic {
        PTR_CPU = 1'b0,
        PTR_DMA = 1'b1
    } ptr_e;

    function automatic ptr_e ptr_other(input ptr_e p);
        return (p == PTR_CPU) ? PTR_DMA : PTR_CPU;
    endfunction

endpackage

// File: rtl/dual_port_arb_ram_if.sv
// One master's request/ack channel into the shared RAM.
interface dual_port_arb_ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  Req;
    logic                  Write;
    logic [ADDR_W-1:0]     Address;
    logic [DATA_W-1:0]     WData;
    logic [DATA_W/8-1:0]   BE;
    logic [DATA_W-1:0]     RData;
    logic                  Ack;
    logic                  Err;

    modport master (
        output Req, Write, Address, WData, BE,
        input  RData, Ack, Err
    );

    modport slave (
        input  Req, Write, Address, WData, BE,
        output RData, Ack, Err
    );
endinterface

// File: rtl/dual_port_arb_ram_arbiter2.sv
// Two-master arbiter: eligibility, one-hot grant, and the round-robin pointer
// that flips only when both masters competed in the same cycle.
module ram_arbiter2
    import dual_port_arb_ram_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_MST-1:0] i_req,
    input  logic [NUM_MST-1:0] i_ack,
    output logic [NUM_MST-1:0] o_grant
);

    logic [NUM_MST-1:0] w_elig;
    logic               w_both;
    ptr_e               r_ptr;
    ptr_e               w_ptr_nxt;

    // A master being acked this cycle must not be served again on the same request.
    assign w_elig = i_req & ~i_ack;
    assign w_both = &w_elig;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_ptr <= PTR_CPU;
        else     r_ptr <= w_ptr_nxt;
    end

    always_comb begin
        w_ptr_nxt = r_ptr;
        if (ARB_MODE == ARB_RR && w_both) w_ptr_nxt = ptr_other(r_ptr);
    end

    always_comb begin
        o_grant = '0;
        if (w_both) begin
            if (ARB_MODE == ARB_CPU_PRIO || r_ptr == PTR_CPU) o_grant[MST_CPU] = 1'b1;
            else                                              o_grant[MST_DMA] = 1'b1;
        end else begin
            o_grant = w_elig;
        end
    end

endmodule

// File: rtl/dual_port_arb_ram.sv
// Single-bank RAM shared by CPU and DMA masters; one arbitrated access per
// cycle with byte-enabled writes and out-of-range error reporting.
module dual_port_arb_ram
    import dual_port_arb_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = 32,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic               CLK,
    input  logic               RST,
    dual_port_arb_ram_if.slave CPU,
    dual_port_arb_ram_if.slave DMA
);

    localparam int          BE_W    = DATA_W / 8;
    localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] DEPTH_L = 64'(DEPTH);

    logic [NUM_MST-1:0]             w_req;
    logic [NUM_MST-1:0]             w_write;
    logic [NUM_MST-1:0][ADDR_W-1:0] w_addr;
    logic [NUM_MST-1:0][DATA_W-1:0] w_wdata;
    logic [NUM_MST-1:0][BE_W-1:0]   w_be;
    logic [NUM_MST-1:0]             w_oob;
    logic [NUM_MST-1:0]             w_grant;

    logic                           w_sel;
    logic                           w_do;
    logic [IDX_W-1:0]               w_idx;
    logic [DATA_W-1:0]              w_rd_word;

    logic [DATA_W-1:0]              r_mem [DEPTH];
    logic [NUM_MST-1:0]             r_ack;
    logic [NUM_MST-1:0]             r_err;
    logic [NUM_MST-1:0][DATA_W-1:0] r_rdata;

    assign w_req   = {DMA.Req,     CPU.Req};
    assign w_write = {DMA.Write,   CPU.Write};
    assign w_addr  = {DMA.Address, CPU.Address};
    assign w_wdata = {DMA.WData,   CPU.WData};
    assign w_be    = {DMA.BE,      CPU.BE};

    // Full-width compare: high address bits never alias back into the array.
    for (genvar m = 0; m < NUM_MST; m++) begin : g_range
        assign w_oob[m] = 64'(w_addr[m]) >= DEPTH_L;
    end

    ram_arbiter2 #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .i_req   (w_req),
        .i_ack   (r_ack),
        .o_grant (w_grant)
    );

    assign w_sel     = w_grant[MST_DMA];
    assign w_do      = (|w_grant) && !RST;
    assign w_idx     = w_addr[w_sel][IDX_W-1:0];
    assign w_rd_word = r_mem[w_idx];

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (w_do && w_write[w_sel] && !w_oob[w_sel]) begin
            for (int b = 0; b < BE_W; b++) begin
                if (w_be[w_sel][b]) r_mem[w_idx][8*b +: 8] <= w_wdata[w_sel][8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ack   <= '0;
            r_err   <= '0;
            r_rdata <= '0;
        end else begin
            for (int m = 0; m < NUM_MST; m++) begin
                r_ack[m] <= w_grant[m];
                r_err[m] <= w_grant[m] & w_oob[m];
                // Writes leave the read-data register alone; errors clear it.
                if (w_grant[m]) begin
                    if (w_oob[m])        r_rdata[m] <= '0;
                    else if (!w_write[m]) r_rdata[m] <= w_rd_word;
                end
            end
        end
    end

    assign CPU.Ack   = r_ack[MST_CPU];
    assign CPU.Err   = r_err[MST_CPU];
    assign CPU.RData = r_rdata[MST_CPU];
    assign DMA.Ack   = r_ack[MST_DMA];
    assign DMA.Err   = r_err[MST_DMA];
    assign DMA.RData = r_rdata[MST_DMA];

endmodule

// File: tb/tb_dual_port_arb_ram.sv
// Runs a round-robin instance and a CPU-priority instance side by side against
// a transaction-level model of each, plus directed literal expectations.
module tb_dual_port_arb_ram;
    import dual_port_arb_ram_pkg::*;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index [d][p]: d=0 round-robin instance, d=1 CPU-priority instance; p=0 CPU, p=1 DMA.
    logic [1:0][1:0] s_req;
    logic [1:0][1:0] s_wr;
    logic [31:0]     s_addr  [2][2];
    logic [31:0]     s_wdata [2][2];
    logic [3:0]      s_be    [2][2];
    logic [1:0][1:0] d_ack;
    logic [1:0][1:0] d_err;
    logic [31:0]     d_rdata [2][2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        dual_port_arb_ram_if #(.ADDR_W(32), .DATA_W(32)) cpu_if ();
        dual_port_arb_ram_if #(.ADDR_W(32), .DATA_W(32)) dma_if ();

        assign cpu_if.Req     = s_req[d][0];
        assign cpu_if.Write   = s_wr[d][0];
        assign cpu_if.Address = s_addr[d][0];
        assign cpu_if.WData   = s_wdata[d][0];
        assign cpu_if.BE      = s_be[d][0];
        assign dma_if.Req     = s_req[d][1];
        assign dma_if.Write   = s_wr[d][1];
        assign dma_if.Address = s_addr[d][1];
        assign dma_if.WData   = s_wdata[d][1];
        assign dma_if.BE      = s_be[d][1];

        assign d_ack[d][0]   = cpu_if.Ack;
        assign d_err[d][0]   = cpu_if.Err;
        assign d_rdata[d][0] = cpu_if.RData;
        assign d_ack[d][1]   = dma_if.Ack;
        assign d_err[d][1]   = dma_if.Err;
        assign d_rdata[d][1] = dma_if.RData;

        dual_port_arb_ram #(
            .DATA_W   (32),
            .DEPTH    (DEPTH),
            .ADDR_W   (32),
            .ARB_MODE (d == 0 ? ARB_RR : ARB_CPU_PRIO)
        ) u_dut (
            .CLK (clk),
            .RST (rst),
            .CPU (cpu_if.slave),
            .DMA (dma_if.slave)
        );
    end

    int n_checks = 0;
    int n_err    = 0;

    // Model state: random in-range traffic stays within words 0..15.
    logic [31:0] m_mem   [2][16];
    bit          m_ack   [2][2];
    bit          m_err   [2][2];
    logic [31:0] m_rdata [2][2];
    bit          m_turn_dma [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_turn_dma[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_ack[d][p]   = 1'b0;
                m_err[d][p]   = 1'b0;
                m_rdata[d][p] = '0;
            end
        end
    endtask

    // What each instance must show after the coming clock edge, given the inputs now.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit want0, want1;
            int win;
            want0 = s_req[d][0] && !m_ack[d][0];
            want1 = s_req[d][1] && !m_ack[d][1];
            win = -1;
            if (want0 && want1) begin
                if (d == 1) win = 0;
                else begin
                    win = m_turn_dma[d] ? 1 : 0;
                    m_turn_dma[d] = !m_turn_dma[d];
                end
            end else if (want0) win = 0;
            else if (want1)     win = 1;
            for (int p = 0; p < 2; p++) begin
                m_ack[d][p] = 1'b0;
                m_err[d][p] = 1'b0;
            end
            if (win >= 0) begin
                logic [31:0] a;
                a = s_addr[d][win];
                m_ack[d][win] = 1'b1;
                if (a >= 32'(DEPTH)) begin
                    m_err[d][win]   = 1'b1;
                    m_rdata[d][win] = '0;
                end else if (s_wr[d][win]) begin
                    for (int b = 0; b < 4; b++)
                        if (s_be[d][win][b]) m_mem[d][a[3:0]][8*b +: 8] = s_wdata[d][win][8*b +: 8];
                end else begin
                    m_rdata[d][win] = m_mem[d][a[3:0]];
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("model d%0d p%0d ack", d, p),   32'(d_ack[d][p]), 32'(m_ack[d][p]));
                chk($sformatf("model d%0d p%0d err", d, p),   32'(d_err[d][p]), 32'(m_err[d][p]));
                chk($sformatf("model d%0d p%0d rdata", d, p), d_rdata[d][p],    m_rdata[d][p]);
            end
    endtask

    task automatic cycle();
        if (!rst) model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Uncontended access on port p of both instances; Ack must follow in one cycle.
    task automatic access(input int p, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input bit exp_err);
        for (int d = 0; d < 2; d++) begin
            s_req[d][p] = 1'b1; s_wr[d][p] = wr; s_addr[d][p] = a;
            s_wdata[d][p] = wd; s_be[d][p] = be;
        end
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("lit d%0d p%0d ack latency", d, p), 32'(d_ack[d][p]), 32'd1);
            chk($sformatf("lit d%0d p%0d err", d, p),         32'(d_err[d][p]), 32'(exp_err));
            s_req[d][p] = 1'b0;
        end
        cycle();
    endtask

    task automatic new_req(input int d, input int p);
        logic [31:0] a;
        case ($urandom_range(0, 15))
            0:       a = 32'(DEPTH);
            1:       a = 32'h8000_0005;
            2:       a = 32'hFFFF_FFFF;
            3:       a = $urandom | 32'h0000_0400;
            default: a = 32'($urandom_range(0, 15));
        endcase
        s_req[d][p]   = 1'b1;
        s_wr[d][p]    = 1'($urandom_range(0, 1));
        s_addr[d][p]  = a;
        s_wdata[d][p] = $urandom;
        s_be[d][p]    = 4'($urandom_range(0, 15));
    endtask

    initial begin
        int cnt [2][2];
        s_req = '0;
        s_wr  = '0;
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) begin
                s_addr[d][p] = '0; s_wdata[d][p] = '0; s_be[d][p] = '0;
                cnt[d][p] = 0;
            end
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;

        for (int a = 0; a < 16; a++)
            access(0, 1'b1, 32'(a), 32'h5A00_0000 + 32'(a) * 32'h0001_0101, 4'hF, 1'b0);

        access(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 4'hF, 1'b0);
        access(0, 1'b0, 32'd5, 32'h0, 4'h0, 1'b0);
        for (int d = 0; d < 2; d++) chk($sformatf("lit d%0d cpu read 5", d), d_rdata[d][0], 32'hDEAD_BEEF);

        access(0, 1'b1, 32'd7, 32'h1122_3344, 4'hF, 1'b0);
        access(1, 1'b1, 32'd7, 32'hAABB_CCDD, 4'b0101, 1'b0);
        access(0, 1'b0, 32'd7, 32'h0, 4'h0, 1'b0);
        for (int d = 0; d < 2; d++) chk($sformatf("lit d%0d byte merge", d), d_rdata[d][0], 32'h11BB_33DD);

        access(1, 1'b0, 32'd5, 32'h0, 4'h0, 1'b0);
        access(1, 1'b0, 32'(DEPTH), 32'h0, 4'h0, 1'b1);
        for (int d = 0; d < 2; d++) chk($sformatf("lit d%0d oob rdata", d), d_rdata[d][1], 32'h0);
        access(1, 1'b0, 32'd5, 32'h0, 4'h0, 1'b0);
        access(1, 1'b0, 32'h8000_0005, 32'h0, 4'h0, 1'b1);
        for (int d = 0; d < 2; d++) chk($sformatf("lit d%0d high-bit oob rdata", d), d_rdata[d][1], 32'h0);
        access(1, 1'b1, 32'h8000_0005, 32'h0, 4'hF, 1'b1);
        access(0, 1'b1, 32'd5, 32'h0, 4'h0, 1'b0);
        access(1, 1'b0, 32'd5, 32'h0, 4'h0, 1'b0);
        for (int d = 0; d < 2; d++) chk($sformatf("lit d%0d addr 5 intact", d), d_rdata[d][1], 32'hDEAD_BEEF);

        // Both masters hold requests for eight edges.
        for (int d = 0; d < 2; d++) begin
            s_req[d] = 2'b11; s_wr[d] = 2'b00;
            s_addr[d][0] = 32'd0; s_addr[d][1] = 32'd1;
        end
        for (int k = 0; k < 8; k++) begin
            cycle();
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("lit d%0d one ack per cycle", d), 32'(d_ack[d][0] ^ d_ack[d][1]), 32'd1);
                if (k == 0) chk($sformatf("lit d%0d first ack cpu", d), 32'(d_ack[d][0]), 32'd1);
                cnt[d][0] += int'(d_ack[d][0]);
                cnt[d][1] += int'(d_ack[d][1]);
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("lit d%0d cpu acks", d), 32'(cnt[d][0]), 32'd4);
            chk($sformatf("lit d%0d dma acks", d), 32'(cnt[d][1]), 32'd4);
            s_req[d] = 2'b00;
        end
        cycle();

        // Asynchronous reset while a CPU request is being acknowledged and still held.
        for (int d = 0; d < 2; d++) begin
            s_req[d][0] = 1'b1; s_wr[d][0] = 1'b0; s_addr[d][0] = 32'd5;
        end
        cycle();
        for (int d = 0; d < 2; d++) chk($sformatf("lit d%0d pre-reset rdata", d), d_rdata[d][0], 32'hDEAD_BEEF);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("lit d%0d async ack", d),   32'(d_ack[d][0]), 32'd0);
            chk($sformatf("lit d%0d async rdata", d), d_rdata[d][0],    32'd0);
            chk($sformatf("lit d%0d async err", d),   32'(d_err[d][0]), 32'd0);
        end
        cycle();
        #2;
        rst = 1'b0;
        cycle();
        for (int d = 0; d < 2; d++) chk($sformatf("lit d%0d post-reset ack", d), 32'(d_ack[d][0]), 32'd1);
        for (int d = 0; d < 2; d++) s_req[d][0] = 1'b0;
        cycle();

        // Simultaneous requests right after reset: the pointer names the CPU.
        for (int d = 0; d < 2; d++) s_req[d] = 2'b11;
        cycle();
        for (int d = 0; d < 2; d++) chk($sformatf("lit d%0d pointer cpu", d), 32'(d_ack[d][0]), 32'd1);
        cycle();
        for (int d = 0; d < 2; d++) s_req[d] = 2'b00;
        cycle();
        // Pointer now names the DMA; only the priority instance still favours the CPU.
        for (int d = 0; d < 2; d++) s_req[d] = 2'b11;
        cycle();
        chk("lit rr pointer dma", 32'(d_ack[0][1]), 32'd1);
        chk("lit prio cpu wins",  32'(d_ack[1][0]), 32'd1);
        cycle();
        for (int d = 0; d < 2; d++) s_req[d] = 2'b00;
        cycle();

        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    if (s_req[d][p] && m_ack[d][p]) begin
                        if ($urandom_range(0, 1) == 1) new_req(d, p);
                        else s_req[d][p] = 1'b0;
                    end else if (!s_req[d][p]) begin
                        if ($urandom_range(0, 2) == 0) new_req(d, p);
                    end else if ($urandom_range(0, 19) == 0) begin
                        s_req[d][p] = 1'b0;
                    end
                end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
